// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW result path.
// Contents:
//   - word indices of a serialised result triplet
//   - the collector state enum
//   - the number of words per result
package dtw_pkg;

    // Position of each word within the serialised result triplet.
    localparam int unsigned W_QID = 0;
    localparam int unsigned W_POS = 1;
    localparam int unsigned W_VAL = 2;
    localparam int unsigned DTW_RES_WORDS = 3;

    // Each read state's encoding equals the index of the word it reads.
    // EMIT follows the last word.
    typedef enum logic [1:0] {
        RD_QID = 2'(W_QID),
        RD_POS = 2'(W_POS),
        RD_VAL = 2'(W_VAL),
        EMIT   = 2'(DTW_RES_WORDS)
    } dtw_state_e;

endpackage

// File: rtl/dtw_sat_counter.sv
// Saturating up-counter used for the collector status registers.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-low reset
//   clear - synchronous clear, has priority over inc
//   inc   - increment enable
//   count - current count, sticks at all-ones
module dtw_sat_counter #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [width-1:0] count
);

    logic [width-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dtw_result_collector.sv
// Drains the DTW sink FIFO (query id, best position, minimum cost), reassembles
// each triplet into one record, classifies it against a threshold and hands it
// downstream on a valid/ready interface. Keeps saturating query/hit counters.
// Ports:
//   clk, rst               - clock, asynchronous active-low reset
//   clear                  - sync clear of counters/fmt_err, aborts partial record
//   threshold              - hit threshold (low dtw_dwidth bits used)
//   fifo_empty, fifo_data  - first-word-fall-through FIFO head
//   fifo_rden              - pop strobe (combinational)
//   out_valid, out_ready   - record handshake
//   out_qid, out_position, out_minval, out_hit - record fields
//   query_count, hit_count - accepted records / accepted hits
//   fmt_err                - sticky: cost word had nonzero upper bits
module dtw_result_collector #(
    parameter int unsigned dtw_dwidth = 16,
    parameter int unsigned axi_dwidth = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [axi_dwidth-1:0] threshold,
    input  logic                  fifo_empty,
    input  logic [31:0]           fifo_data,
    output logic                  fifo_rden,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_qid,
    output logic [31:0]           out_position,
    output logic [dtw_dwidth-1:0] out_minval,
    output logic                  out_hit,
    output logic [axi_dwidth-1:0] query_count,
    output logic [axi_dwidth-1:0] hit_count,
    output logic                  fmt_err
);

    import dtw_pkg::*;

    dtw_state_e            state_q;
    logic                  upper_nz;
    logic [dtw_dwidth-1:0] minval_cap;
    logic                  handshake;

    // Cost words wider than dtw_dwidth are malformed.
    if (dtw_dwidth < 32) begin : g_upper
        assign upper_nz = |fifo_data[31:dtw_dwidth];
    end else begin : g_no_upper
        assign upper_nz = 1'b0;
    end

    if (axi_dwidth > dtw_dwidth) begin : g_thr
        logic unused_thr;
        assign unused_thr = ^threshold[axi_dwidth-1:dtw_dwidth];
    end

    always_comb begin
        minval_cap = upper_nz ? '1 : fifo_data[dtw_dwidth-1:0];
    end

    assign fifo_rden = !clear && !fifo_empty && (state_q != EMIT);
    assign handshake = out_valid && out_ready && !clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RD_QID;
            out_valid    <= 1'b0;
            out_qid      <= '0;
            out_position <= '0;
            out_minval   <= '0;
            out_hit      <= 1'b0;
            fmt_err      <= 1'b0;
        end else if (clear) begin
            // Any partial or pending record is dropped.
            state_q   <= RD_QID;
            out_valid <= 1'b0;
            fmt_err   <= 1'b0;
        end else begin
            unique case (state_q)
                RD_QID: begin
                    if (!fifo_empty) begin
                        out_qid <= fifo_data;
                        state_q <= RD_POS;
                    end
                end
                RD_POS: begin
                    if (!fifo_empty) begin
                        out_position <= fifo_data;
                        state_q      <= RD_VAL;
                    end
                end
                RD_VAL: begin
                    if (!fifo_empty) begin
                        out_minval <= minval_cap;
                        // Classified once here; later threshold writes do not
                        // affect the pending record.
                        out_hit    <= minval_cap < threshold[dtw_dwidth-1:0];
                        if (upper_nz) begin
                            fmt_err <= 1'b1;
                        end
                        out_valid  <= 1'b1;
                        state_q    <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= RD_QID;
                    end
                end
                default: begin
                    state_q   <= RD_QID;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    dtw_sat_counter #(
        .width (axi_dwidth)
    ) u_query_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (handshake),
        .count (query_count)
    );

    dtw_sat_counter #(
        .width (axi_dwidth)
    ) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (handshake && out_hit),
        .count (hit_count)
    );

endmodule

// File: tb/tb_dtw_result_collector.sv
module tb_dtw_result_collector;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [31:0] threshold;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_rden;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_qid;
    logic [31:0] out_position;
    logic [15:0] out_minval;
    logic        out_hit;
    logic [31:0] query_count;
    logic [31:0] hit_count;
    logic        fmt_err;

    // Standalone narrow counter to reach saturation quickly.
    logic        sc_clear;
    logic        sc_inc;
    logic [2:0]  sc_count;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    bit pop_now = 0;
    logic [31:0] src_q[$];

    // Behavioural model: words gathered so far, pending record, counters.
    logic [31:0] m_words[3];
    int          m_phase;
    bit          m_pending;
    logic [31:0] e_qid;
    logic [31:0] e_pos;
    logic [15:0] e_val;
    bit          e_hit;
    logic [31:0] m_qc;
    logic [31:0] m_hc;
    bit          m_ferr;

    dtw_result_collector #(
        .dtw_dwidth (16),
        .axi_dwidth (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .threshold    (threshold),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rden    (fifo_rden),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_qid      (out_qid),
        .out_position (out_position),
        .out_minval   (out_minval),
        .out_hit      (out_hit),
        .query_count  (query_count),
        .hit_count    (hit_count),
        .fmt_err      (fmt_err)
    );

    dtw_sat_counter #(
        .width (3)
    ) u_sc (
        .clk   (clk),
        .rst   (rst),
        .clear (sc_clear),
        .inc   (sc_inc),
        .count (sc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic upd_fifo();
        fifo_empty = (src_q.size() == 0);
        fifo_data  = fifo_empty ? 32'h0 : src_q[0];
    endtask

    task automatic push(input logic [31:0] w);
        src_q.push_back(w);
        upd_fifo();
    endtask

    // Advance n clocks; inputs change and FIFO pops land 1 time unit after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (pop_now) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                pops++;
            end
            upd_fifo();
        end
    endtask

    // Compare against the model every cycle, then advance the model to what
    // must hold after the coming edge.
    always @(negedge clk) begin
        pop_now = rst && fifo_rden;
        if (!rst) begin
            m_phase = 0; m_pending = 0; m_qc = 0; m_hc = 0; m_ferr = 0;
        end else begin
            chk("rden", 32'(fifo_rden), 32'(!clear && !fifo_empty && !m_pending));
            chk("valid", 32'(out_valid), 32'(m_pending));
            if (m_pending) begin
                chk("qid", out_qid, e_qid);
                chk("pos", out_position, e_pos);
                chk("minval", 32'(out_minval), 32'(e_val));
                chk("hit", 32'(out_hit), 32'(e_hit));
            end
            chk("qcount", query_count, m_qc);
            chk("hcount", hit_count, m_hc);
            chk("fmt_err", 32'(fmt_err), 32'(m_ferr));

            if (clear) begin
                m_phase = 0; m_pending = 0; m_qc = 0; m_hc = 0; m_ferr = 0;
            end else if (m_pending) begin
                if (out_ready) begin
                    m_pending = 0;
                    if (m_qc != 32'hFFFF_FFFF) m_qc = m_qc + 1;
                    if (e_hit && m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 1;
                end
            end else if (!fifo_empty) begin
                m_words[m_phase] = fifo_data;
                m_phase++;
                if (m_phase == 3) begin
                    e_qid = m_words[0];
                    e_pos = m_words[1];
                    if (m_words[2] > 32'h0000_FFFF) begin
                        e_val  = 16'hFFFF;
                        m_ferr = 1;
                    end else begin
                        e_val = m_words[2][15:0];
                    end
                    e_hit     = e_val < threshold[15:0];
                    m_pending = 1;
                    m_phase   = 0;
                end
            end
        end
    end

    initial begin
        int p0;
        rst = 1'b0; clear = 1'b0; threshold = 32'h100; out_ready = 1'b1;
        sc_clear = 1'b0; sc_inc = 1'b0;
        upd_fifo();
        tick(3);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_qid", out_qid, 32'h0);
        chk("rst_qcount", query_count, 32'h0);
        chk("rst_rden", 32'(fifo_rden), 32'h0);
        rst = 1'b1;

        // Single record
        push(32'h7); push(32'h1234); push(32'h50);
        tick(2);
        chk("single_early_valid", 32'(out_valid), 32'h0);
        tick(1);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_qid", out_qid, 32'h7);
        chk("single_pos", out_position, 32'h1234);
        chk("single_minval", 32'(out_minval), 32'h50);
        chk("single_hit", 32'(out_hit), 32'h1);
        tick(1);
        chk("single_qcount", query_count, 32'h1);
        chk("single_hcount", hit_count, 32'h1);

        // Backpressure with two records queued
        out_ready = 1'b0;
        push(32'h11); push(32'h22); push(32'h33);
        push(32'h44); push(32'h55); push(32'h200);
        p0 = pops;
        tick(10);
        chk("bp_pops", 32'(pops - p0), 32'h3);
        chk("bp_left", 32'(src_q.size()), 32'h3);
        chk("bp_qid", out_qid, 32'h11);
        out_ready = 1'b1;
        tick(1);
        chk("bp_drop_valid", 32'(out_valid), 32'h0);
        tick(3);
        chk("bp_second_valid", 32'(out_valid), 32'h1);
        chk("bp_second_qid", out_qid, 32'h44);
        chk("bp_second_hit", 32'(out_hit), 32'h0);
        tick(1);
        chk("bp_qcount", query_count, 32'h3);
        chk("bp_hcount", hit_count, 32'h2);

        // Cost equal to threshold is not a hit
        push(32'h9); push(32'hA); push(32'h100);
        tick(3);
        chk("bound_hit", 32'(out_hit), 32'h0);
        tick(1);
        chk("bound_hcount", hit_count, 32'h2);
        chk("bound_qcount", query_count, 32'h4);

        // Format error, then a good record keeps the sticky flag
        push(32'hB); push(32'hC); push(32'h0001_0005);
        tick(3);
        chk("fmt_minval", 32'(out_minval), 32'hFFFF);
        chk("fmt_flag", 32'(fmt_err), 32'h1);
        tick(1);
        push(32'hD); push(32'hE); push(32'h5);
        tick(4);
        chk("fmt_sticky", 32'(fmt_err), 32'h1);
        chk("fmt_qcount", query_count, 32'h6);
        chk("fmt_hcount", hit_count, 32'h3);

        // Threshold change does not reclassify a pending record
        out_ready = 1'b0;
        push(32'h20); push(32'h21); push(32'h80);
        tick(3);
        threshold = 32'h10;
        tick(2);
        chk("thr_hold_hit", 32'(out_hit), 32'h1);
        out_ready = 1'b1;
        tick(1);
        chk("thr_hcount", hit_count, 32'h4);
        threshold = 32'h100;

        // Clear after the position pop
        push(32'h30); push(32'h31);
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_valid", 32'(out_valid), 32'h0);
        chk("clr_qcount", query_count, 32'h0);
        chk("clr_hcount", hit_count, 32'h0);
        chk("clr_fmt", 32'(fmt_err), 32'h0);
        push(32'h40); push(32'h41); push(32'h42);
        tick(3);
        chk("clr_next_qid", out_qid, 32'h40);
        chk("clr_next_pos", out_position, 32'h41);
        chk("clr_next_minval", 32'(out_minval), 32'h42);
        tick(1);
        chk("clr_next_qcount", query_count, 32'h1);

        // Clear drops a pending record uncounted
        out_ready = 1'b0;
        push(32'h50); push(32'h51); push(32'h52);
        tick(3);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        out_ready = 1'b1;
        tick(2);
        chk("clr_pend_valid", 32'(out_valid), 32'h0);
        chk("clr_pend_qcount", query_count, 32'h0);

        // Saturation on a narrow counter
        sc_inc = 1'b1;
        tick(2);
        chk("sat_two", 32'(sc_count), 32'h2);
        tick(5);
        chk("sat_max", 32'(sc_count), 32'h7);
        tick(3);
        chk("sat_hold", 32'(sc_count), 32'h7);
        sc_clear = 1'b1;
        tick(1);
        sc_clear = 1'b0; sc_inc = 1'b0;
        chk("sat_clear", 32'(sc_count), 32'h0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtw_result_collector.md
# dtw_result_collector

Downstream stage of the DTW core. It drains the core's sink FIFO, which carries three serialised 32-bit words per query: query id, best position and minimum DTW cost. It reassembles each triplet into one parallel record, classifies the record as a hit when the cost is below a programmable threshold, and presents the record on a valid/ready interface to the host-side result path. It also keeps saturating query and hit counters for status readback.

## Interface
- `dtw_dwidth`, 16: width of the DTW cost value; must be ≤ 32.
- `axi_dwidth`, 32: width of the threshold and counter registers.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous; clears the counters and `fmt_err`, and aborts any partial record.
- `threshold` in `axi_dwidth`: hit threshold. Only the low `dtw_dwidth` bits are used.
- `fifo_empty` in 1: sink FIFO empty flag.
- `fifo_data` in 32: sink FIFO head word. The FIFO is first-word-fall-through, so the word is valid whenever `!fifo_empty`.
- `fifo_rden` out 1: pop strobe, combinational. It is asserted only in a read state while `!fifo_empty`.
- `out_valid` out 1: record valid.
- `out_ready` in 1: consumer accepts the record.
- `out_qid` out 32: query id.
- `out_position` out 32: best reference position.
- `out_minval` out `dtw_dwidth`: minimum DTW cost.
- `out_hit` out 1: asserted when `out_minval < threshold[dtw_dwidth-1:0]`.
- `query_count` out `axi_dwidth`: number of records accepted downstream.
- `hit_count` out `axi_dwidth`: number of accepted records with `out_hit` = 1.
- `fmt_err` out 1: sticky flag; set when the cost word has nonzero upper bits.

## Operation
- The FSM has four states: `RD_QID` → `RD_POS` → `RD_VAL` → `EMIT` → `RD_QID`. The reset state is `RD_QID`.
- In each `RD_*` state:
  - If `fifo_empty` = 0, the block asserts `fifo_rden`, captures `fifo_data` into that state's field register, and advances to the next state.
  - If the FIFO is empty, the block holds its state and `fifo_rden` = 0.
- `RD_VAL` capture:
  - `out_minval` takes `fifo_data[dtw_dwidth-1:0]`.
  - If `fifo_data[31:dtw_dwidth]` ≠ 0, `out_minval` saturates to all-ones and `fmt_err` is set.
  - `out_hit` is registered at the same edge, compared against the current `threshold`.
- In `EMIT`:
  - `out_valid` = 1, and all `out_*` fields are held stable until `out_ready`.
  - No FIFO reads occur.
  - On `out_valid & out_ready`, the block returns to `RD_QID`, increments `query_count`, and increments `hit_count` if `out_hit` = 1.
- Counters saturate at 2^`axi_dwidth` − 1; they never wrap.
- `clear` has priority over all other activity:
  - It zeroes both counters and `fmt_err`.
  - It forces the state to `RD_QID` with `out_valid` = 0. A record pending in `EMIT` is dropped and not counted.
  - `fifo_rden` = 0 in any cycle where `clear` = 1.
- A `threshold` change takes effect for the next `RD_VAL` capture. It does not reclassify a record already pending.
- Asynchronous reset mid-record:
  - The partial record is discarded.
  - Words already popped from the FIFO are lost, so the FIFO must be flushed by the same reset domain.

## Timing
- Reset values: all outputs are 0, state is `RD_QID`, and all field registers are 0.
- Latency: `out_valid` rises one cycle after the cycle in which the cost word is popped.
- Throughput: at most one record per 4 cycles, made up of 3 pops and 1 emit. Back-to-back records occur when `out_ready` is held at 1 and the FIFO is never empty.
- `out_valid` never deasserts without a handshake, except on `clear` or reset.
- Counters update at the handshake edge and are visible the following cycle.
- When a handshake and counter saturation occur in the same cycle, the counter stays at its maximum value.

## Structure
- Package `dtw_pkg` holds:
  - the state enum (`RD_QID`, `RD_POS`, `RD_VAL`, `EMIT`);
  - the word-index constants (`W_QID`=0, `W_POS`=1, `W_VAL`=2);
  - `DTW_RES_WORDS`=3.
- One sub-module, `dtw_sat_counter`:
  - parameterised width;
  - inputs: increment enable and synchronous clear;
  - output: saturating count.
  - It is instantiated twice, once for `query_count` and once for `hit_count`.

## Test plan
- **Single record:** push words 0x7, 0x1234, 0x0050 with `threshold` = 0x0100 and `out_ready` = 1.
  - Expect `out_qid` = 7, `out_position` = 0x1234, `out_minval` = 0x50, `out_hit` = 1.
  - Expect `query_count` = 1, `hit_count` = 1, and `out_valid` 1 cycle after the third pop.
- **Backpressure:** hold `out_ready` = 0 for 10 cycles with 6 words queued.
  - Expect exactly 3 pops, fields stable, and no 4th pop until the handshake.
  - Then expect the second record to emit 4 cycles after the first.
- **Non-hit and boundary:** send cost = 0x0100 with `threshold` = 0x0100.
  - Expect `out_hit` = 0 and `hit_count` unchanged.
- **Format error:** send a cost word of 0x0001_0005.
  - Expect `out_minval` = 0xFFFF, `fmt_err` = 1, and `fmt_err` still 1 after the next good record.
- **`clear` mid-record:** assert `clear` after the position pop.
  - Expect the state to be `RD_QID`, no emit, and counters = 0.
  - The next 3 words then form a clean record.
- **Saturation:** preload `query_count` to all-ones via a forced counter and complete one handshake.
  - Expect `query_count` to remain 0xFFFF_FFFF.
